// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op codes,
// FSM state type and small op-classification helpers.
package muldiv_pkg;

    localparam logic [2:0] MDNONE = 3'd0;
    localparam logic [2:0] MDMUL  = 3'd1;
    localparam logic [2:0] MDMULU = 3'd2;
    localparam logic [2:0] MDDIV  = 3'd3;
    localparam logic [2:0] MDDIVU = 3'd4;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDDIV) || (op == MDDIVU);
    endfunction

    // Only the four defined ops ever produce a result worth committing.
    function automatic logic is_known(input logic [2:0] op);
        return (op == MDMUL) || (op == MDMULU) || (op == MDDIV) || (op == MDDIVU);
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational arithmetic for the HI/LO unit. The controller latches the
// result in the start cycle and only exposes it after the modelled latency.
// div0 flags a divide by zero so the commit can leave HI/LO untouched.
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    assign sa64   = {{32{a_i[31]}}, a_i};
    assign sb64   = {{32{b_i[31]}}, b_i};
    assign prod_s = sa64 * sb64;
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};
    assign sa     = a_i;
    assign sb     = b_i;

    // Divide paths; zero divisor and the single signed overflow case are
    // resolved explicitly so no operator ever sees an undefined input.
    always_comb begin
        quo_s = '0;
        rem_s = '0;
        quo_u = '0;
        rem_u = '0;
        if (b_i != 32'd0) begin
            if ((a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
                quo_s = sa;
                rem_s = '0;
            end else begin
                quo_s = sa / sb;
                rem_s = sa % sb;
            end
            quo_u = a_i / b_i;
            rem_u = a_i % b_i;
        end
    end

    // Select the result for the requested op.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        div0   = 1'b0;
        case (op_i)
            MDMUL:  {res_hi, res_lo} = prod_s;
            MDMULU: {res_hi, res_lo} = prod_u;
            MDDIV: begin
                res_hi = rem_s;
                res_lo = quo_s;
                div0   = (b_i == 32'd0);
            end
            MDDIVU: begin
                res_hi = rem_u;
                res_lo = quo_u;
                div0   = (b_i == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage controller for the HI/LO multiply/divide resource.
// Holds each op for a fixed latency before committing HI/LO and raises the
// stall that keeps later HI/LO instructions in decode until the unit is free.
// Optional build macro MDU_CANCEL_EN adds cancel_i to abort an op in flight.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  MD_IDLE | unit free; accepts a start or an mthi/mtlo write
//  MD_BUSY | op in flight; cnt counts down, commit at cnt == 0
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef MDU_CANCEL_EN
    input  logic        cancel_i,
`endif
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        hlwe_i,
    input  logic        hl_src_i,
    input  logic        d_md_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] hl_o
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             div0;
    logic             cancel;

`ifdef MDU_CANCEL_EN
    assign cancel = cancel_i;
`else
    assign cancel = 1'b0;
`endif

    muldiv_core u_core (
        .op_i   (op_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    // Next-state: start latches the result; an mt write only lands when no
    // start competes in the same cycle; BUSY counts down to the commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            MD_IDLE: begin
                if (start_i && (op_i != MDNONE)) begin
                    if (!cancel) begin
                        state_d   = MD_BUSY;
                        busy_d    = 1'b1;
                        cnt_d     = is_div(op_i) ? DIV_CNT : MUL_CNT;
                        pend_hi_d = res_hi;
                        pend_lo_d = res_lo;
                        pend_wr_d = is_known(op_i) && !div0;
                    end
                end else if (hlwe_i) begin
                    if (hl_src_i) hi_d = a_i;
                    else          lo_d = a_i;
                end
            end
            MD_BUSY: begin
                if (cancel) begin
                    state_d = MD_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                    busy_d  = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and all HI/LO storage; reset discards any op in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy_o  = busy_q;
    assign stall_o = d_md_i & (start_i | busy_q);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign hl_o    = hl_src_i ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus randomized bench for muldiv_ctrl against an arithmetic
// reference model of HI/LO.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        hlwe_i;
    logic        hl_src_i;
    logic        d_md_i;
    logic        busy_o;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] hl_o;
`ifdef MDU_CANCEL_EN
    logic        cancel_i;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
`ifdef MDU_CANCEL_EN
        .cancel_i (cancel_i),
`endif
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .hlwe_i   (hlwe_i),
        .hl_src_i (hl_src_i),
        .d_md_i   (d_md_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .hl_o     (hl_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on magnitudes, signs applied after.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint            na, nb, ma, mb, q, r;
        longint unsigned   pu;
        longint            ps;
        na = longint'($signed(a));
        nb = longint'($signed(b));
        case (op)
            MDMUL: begin
                ps = na * nb;
                hi_m = ps[63:32];
                lo_m = ps[31:0];
            end
            MDMULU: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                hi_m = pu[63:32];
                lo_m = pu[31:0];
            end
            MDDIV: if (b != 0) begin
                ma = (na < 0) ? -na : na;
                mb = (nb < 0) ? -nb : nb;
                q  = ma / mb;
                r  = ma % mb;
                if ((na < 0) != (nb < 0)) q = -q;
                if (na < 0) r = -r;
                lo_m = q[31:0];
                hi_m = r[31:0];
            end
            MDDIVU: if (b != 0) begin
                lo_m = a / b;
                hi_m = a % b;
            end
            default: ;
        endcase
    endtask

    // Issue one op (optionally with a colliding mt request) and follow it to commit.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dmd, input logic hw);
        int n;
        int lat;
        lat = (op == MDDIV || op == MDDIVU) ? 10 : 5;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b; d_md_i = dmd;
        hlwe_i = hw; hl_src_i = 1'b1;
        #1;
        chk("stall_start", stall_o, dmd);
        chk("busy_start", busy_o, 0);
        @(posedge clk); #1;
        start_i = 1'b0; op_i = MDNONE; hlwe_i = 1'b0; a_i = $urandom; b_i = $urandom;
        n = 0;
        while (busy_o === 1'b1 && n < 20) begin
            n++;
            chk("stall_busy", stall_o, dmd);
            @(posedge clk); #1;
        end
        model_op(op, a, b);
        chk("busy_len", n, lat);
        chk("hi", hi_o, hi_m);
        chk("lo", lo_o, lo_m);
        chk("stall_after", stall_o, 0);
        d_md_i = 1'b0;
    endtask

    task automatic do_mt(input logic src, input logic [31:0] val);
        hlwe_i = 1'b1; hl_src_i = src; a_i = val;
        @(posedge clk); #1;
        hlwe_i = 1'b0; a_i = $urandom;
        if (src) hi_m = val; else lo_m = val;
        chk("mt_hi", hi_o, hi_m);
        chk("mt_lo", lo_o, lo_m);
        chk("mt_busy", busy_o, 0);
        hl_src_i = 1'b1; #1;
        chk("hl_hi", hl_o, hi_m);
        hl_src_i = 1'b0; #1;
        chk("hl_lo", hl_o, lo_m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [31:0] ra, rb;
        reset_n = 1'b0; start_i = 1'b0; op_i = MDNONE; a_i = '0; b_i = '0;
        hlwe_i = 1'b0; hl_src_i = 1'b0; d_md_i = 1'b0;
`ifdef MDU_CANCEL_EN
        cancel_i = 1'b0;
`endif
        hi_m = '0; lo_m = '0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_hl", hl_o, 0);
        chk("rst_stall", stall_o, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-derived constants.
        do_op(MDMUL, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        chk("mult_hi_k", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo_k", lo_o, 32'hFFFF_FFFE);
        do_op(MDMULU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        chk("multu_hi_k", hi_o, 32'h0000_0001);
        chk("multu_lo_k", lo_o, 32'hFFFF_FFFE);
        do_op(MDDIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        chk("div_lo_k", lo_o, 32'hFFFF_FFFD);
        chk("div_hi_k", hi_o, 32'h0000_0001);
        do_op(MDDIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("divovf_lo_k", lo_o, 32'h8000_0000);
        chk("divovf_hi_k", hi_o, 32'h0000_0000);
        do_op(MDDIVU, 32'd1234, 32'd0, 1'b0, 1'b0);
        chk("divu0_lo_k", lo_o, 32'h8000_0000);
        chk("divu0_hi_k", hi_o, 32'h0000_0000);
        do_mt(1'b1, 32'h1234_5678);
        chk("mthi_k", hi_o, 32'h1234_5678);
        chk("mthi_lo_k", lo_o, 32'h8000_0000);
        do_mt(1'b0, 32'hCAFE_0000);
        // start and mt in the same cycle: the mt is dropped.
        do_op(MDMULU, 32'd3, 32'd4, 1'b0, 1'b1);
        chk("collide_hi_k", hi_o, 32'd0);
        chk("collide_lo_k", lo_o, 32'd12);
        do_op(MDDIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);

        // Randomized ops and mt writes.
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 4);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (r == 4) do_mt(1'($urandom_range(0, 1)), ra);
            else        do_op(3'(r + 1), ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the third busy cycle of a divide: nothing may commit later.
        do_mt(1'b1, 32'hAAAA_5555);
        do_mt(1'b0, 32'h0F0F_0F0F);
        start_i = 1'b1; op_i = MDDIV; a_i = 32'd100; b_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = MDNONE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", busy_o, 1);
        reset_n = 1'b0; #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_hi", hi_o, 0);
        chk("midrst_lo", lo_o, 0);
        hi_m = '0; lo_m = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("postrst_busy", busy_o, 0);
        chk("postrst_hi", hi_o, 0);
        chk("postrst_lo", lo_o, 0);

`ifdef MDU_CANCEL_EN
        do_mt(1'b1, 32'h1111_2222);
        start_i = 1'b1; op_i = MDMULU; a_i = 32'd5; b_i = 32'd6;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = MDNONE;
        cancel_i = 1'b1;
        @(posedge clk); #1;
        cancel_i = 1'b0;
        chk("cancel_busy", busy_o, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("cancel_hi", hi_o, hi_m);
        chk("cancel_lo", lo_o, lo_m);
        start_i = 1'b1; op_i = MDMUL; a_i = 32'd5; b_i = 32'd6; cancel_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = MDNONE; cancel_i = 1'b0;
        chk("cancel_start_busy", busy_o, 0);
`endif

        do_op(MDMUL, 32'd6, 32'hFFFF_FFFD, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
